// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry look-ahead adder family.
// One look-ahead group covers one nibble of the operand word.
package cla_pkg;

  localparam int GROUP_W = 4;

  function automatic int group_count(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit look-ahead unit: carries c1..c4 plus group propagate/generate.
// Used per nibble and again as the second-level unit over group P/G values.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] p,
  input  logic [GROUP_W-1:0] g,
  input  logic               c0,
  output logic [GROUP_W-1:0] c,
  output logic               grp_p,
  output logic               grp_g
);

  // c[0] is c1 (carry into bit 1) through c[3], which is c4 (carry out of the group)
  assign c[0] = g[0]
              | (p[0] & c0);

  assign c[1] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0);

  assign c[2] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

  assign c[3] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

  assign grp_p = p[3] & p[2] & p[1] & p[0];

  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder4.sv
// Registered carry look-ahead adder: {cout, s} = a + b + cin one cycle after in_valid.
// Exports word-level propagate/generate so wider adders can cascade it.
module cla_adder4
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int NG = group_count(WIDTH);

  logic [WIDTH-1:0]              p;
  logic [WIDTH-1:0]              g;
  logic [WIDTH-1:0]              sum;
  logic [NG-1:0]                 gp;
  logic [NG-1:0]                 gg;
  logic [NG-1:0][GROUP_W-1:0]    grp_c;
  logic [NG-1:0]                 grp_c4;
  logic [NG:0]                   gc;
  logic                          word_p;
  logic                          word_g;

  assign p = a ^ b;
  assign g = a & b;

  // gc[k] is the carry into group k; gc[NG] is the word carry-out
  for (genvar k = 0; k < NG; k++) begin : g_group
    cla_group4 u_grp (
      .p     (p[GROUP_W*k +: GROUP_W]),
      .g     (g[GROUP_W*k +: GROUP_W]),
      .c0    (gc[k]),
      .c     (grp_c[k]),
      .grp_p (gp[k]),
      .grp_g (gg[k])
    );

    assign grp_c4[k] = grp_c[k][GROUP_W-1];
    assign sum[GROUP_W*k +: GROUP_W] =
      p[GROUP_W*k +: GROUP_W] ^ {grp_c[k][GROUP_W-2:0], gc[k]};
  end

  if (NG == 1) begin : g_lvl2_none
    assign gc     = {grp_c4[0], cin};
    assign word_p = gp[0];
    assign word_g = gg[0];
  end else if (NG <= GROUP_W) begin : g_lvl2_unit
    logic [GROUP_W-1:0] lp;
    logic [GROUP_W-1:0] lg;
    logic [GROUP_W-1:0] l2c;
    logic               unused_c4;

    // Unused upper slots look like pass-through groups (P=1, G=0) so they leave P/G intact
    always_comb begin
      lp         = '1;
      lg         = '0;
      lp[NG-1:0] = gp;
      lg[NG-1:0] = gg;
    end

    cla_group4 u_lvl2 (
      .p     (lp),
      .g     (lg),
      .c0    (cin),
      .c     (l2c),
      .grp_p (word_p),
      .grp_g (word_g)
    );

    assign gc        = {l2c[NG-1:0], cin};
    assign unused_c4 = ^{grp_c4, l2c};
  end else begin : g_lvl2_loop
    logic [NG:1] carry;
    logic        unused_c4;

    // Sum-of-products look-ahead over all groups, unrolled at elaboration
    always_comb begin
      logic term;
      carry  = '0;
      word_p = &gp;
      word_g = 1'b0;
      term   = 1'b0;
      for (int k = 1; k <= NG; k++) begin
        term = cin;
        for (int m = 0; m < k; m++) term = term & gp[m];
        carry[k] = term;
        for (int j = 0; j < k; j++) begin
          term = gg[j];
          for (int m = j + 1; m < k; m++) term = term & gp[m];
          carry[k] = carry[k] | term;
          if (k == NG) word_g = word_g | term;
        end
      end
    end

    assign gc        = {carry, cin};
    assign unused_c4 = ^grp_c4;
  end

  // Result registers only load on valid; an idle edge just drops out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s     <= sum;
        cout  <= gc[NG];
        grp_p <= word_p;
        grp_g <= word_g;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder4.sv
// Scoreboard bench for cla_adder4 at WIDTH=4 and WIDTH=16 driven side by side.
// Stimulus pushes per-edge expectations; monitors pop and compare after each rising edge.
module tb_cla_adder4;

  typedef struct packed {
    logic       valid;
    logic [3:0] s;
    logic       cout;
    logic       p;
    logic       g;
  } exp4_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] s;
    logic        cout;
    logic        p;
    logic        g;
  } exp16_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        cin = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;

  logic        out_valid4, cout4, grp_p4, grp_g4;
  logic [3:0]  s4;
  logic        out_valid16, cout16, grp_p16, grp_g16;
  logic [15:0] s16;

  int     checks = 0;
  int     errors = 0;
  exp4_t  q4[$];
  exp16_t q16[$];
  exp4_t  last4 = '0;
  exp16_t last16 = '0;
  exp4_t  m4;
  exp16_t m16;

  always #5 clk = ~clk;

  cla_adder4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid4),
    .s         (s4),
    .cout      (cout4),
    .grp_p     (grp_p4),
    .grp_g     (grp_g4)
  );

  cla_adder4 #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a16),
    .b         (b16),
    .cin       (cin),
    .out_valid (out_valid16),
    .s         (s16),
    .cout      (cout16),
    .grp_p     (grp_p16),
    .grp_g     (grp_g16)
  );

  function automatic exp4_t model4(input logic v, input logic [3:0] x, input logic [3:0] y,
                                   input logic c);
    exp4_t      e;
    logic [4:0] full;
    logic [4:0] gen;
    full    = {1'b0, x} + {1'b0, y} + {4'b0, c};
    gen     = {1'b0, x} + {1'b0, y};
    e.valid = v;
    e.s     = full[3:0];
    e.cout  = full[4];
    e.p     = &(x ^ y);
    e.g     = gen[4];
    return e;
  endfunction

  function automatic exp16_t model16(input logic v, input logic [15:0] x, input logic [15:0] y,
                                     input logic c);
    exp16_t      e;
    logic [16:0] full;
    logic [16:0] gen;
    full    = {1'b0, x} + {1'b0, y} + {16'b0, c};
    gen     = {1'b0, x} + {1'b0, y};
    e.valid = v;
    e.s     = full[15:0];
    e.cout  = full[16];
    e.p     = &(x ^ y);
    e.g     = gen[16];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] x, input logic [3:0] y,
                               input logic c, input logic [15:0] x16, input logic [15:0] y16,
                               input exp4_t e4);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
    a16      = x16;
    b16      = y16;
    q4.push_back(e4);
    q16.push_back(model16(v, x16, y16, c));
  endtask

  task automatic applyDirected(input logic [3:0] x, input logic [3:0] y, input logic c,
                               input logic [3:0] es, input logic ec, input logic ep,
                               input logic eg);
    applyStimulus(1'b1, x, y, c, {4{x}}, {4{y}}, exp4_t'{1'b1, es, ec, ep, eg});
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0, exp4_t'(0));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " w4"}, 32'({out_valid4, cout4, s4, grp_p4, grp_g4}), 32'h0);
    checkOutput({tag, " w16"}, 32'({out_valid16, cout16, s16, grp_p16, grp_g16}), 32'h0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (q4.size() > 0) begin
        m4 = q4.pop_front();
        checkOutput("w4 out_valid", 32'(out_valid4), 32'(m4.valid));
        if (m4.valid) begin
          checkOutput("w4 cout,s", 32'({cout4, s4}), 32'({m4.cout, m4.s}));
          checkOutput("w4 grp_p,grp_g", 32'({grp_p4, grp_g4}), 32'({m4.p, m4.g}));
          last4 = m4;
        end else begin
          checkOutput("w4 hold", 32'({cout4, s4, grp_p4, grp_g4}),
                      32'({last4.cout, last4.s, last4.p, last4.g}));
        end
      end else begin
        checkOutput("w4 idle out_valid", 32'(out_valid4), 32'h0);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (q16.size() > 0) begin
        m16 = q16.pop_front();
        checkOutput("w16 out_valid", 32'(out_valid16), 32'(m16.valid));
        if (m16.valid) begin
          checkOutput("w16 cout,s", 32'({cout16, s16}), 32'({m16.cout, m16.s}));
          checkOutput("w16 grp_p,grp_g", 32'({grp_p16, grp_g16}), 32'({m16.p, m16.g}));
          last16 = m16;
        end else begin
          checkOutput("w16 hold", 32'({cout16, s16, grp_p16, grp_g16}),
                      32'({last16.cout, last16.s, last16.p, last16.g}));
        end
      end else begin
        checkOutput("w16 idle out_valid", 32'(out_valid16), 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    rst_n = 1'b0;
    #1;
    checkCleared("reset async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 4'(i + 5);
      b        = 4'(i + 9);
      cin      = 1'b1;
      a16      = 16'($urandom);
      b16      = 16'($urandom);
      @(posedge clk);
      #1;
      checkCleared("reset hold");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    applyDirected(4'b0100, 4'b1000, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0);
    applyDirected(4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
    applyDirected(4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
    applyDirected(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    applyDirected(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
    applyDirected(4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0);
    applyDirected(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyDirected(4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
    applyIdle();
    applyDirected(4'b0110, 4'b0111, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0);
    applyIdle();
    applyIdle();

    applyStimulus(1'b1, 4'd7, 4'd9, 1'b0, 16'h1234, 16'hF00D, model4(1'b1, 4'd7, 4'd9, 1'b0));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q4.delete();
    q16.delete();
    last4  = '0;
    last16 = '0;
    #1;
    checkCleared("mid reset async");
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkCleared("mid reset hold");
    @(negedge clk);
    rst_n = 1'b1;
    applyIdle();

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      applyStimulus(1'b1, v[3:0], v[7:4], v[8], 16'($urandom), 16'($urandom),
                    model4(1'b1, v[3:0], v[7:4], v[8]));
    end
    applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, model4(1'b1, 4'hF, 4'hF, 1'b1));
    applyIdle();
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, model4(1'b1, 4'h0, 4'h0, 1'b0));
    applyStimulus(1'b1, 4'h8, 4'h8, 1'b0, 16'hAAAA, 16'h5555, model4(1'b1, 4'h8, 4'h8, 1'b0));
    applyIdle();

    repeat (3) @(posedge clk);
    #2;
    checkOutput("w4 scoreboard drained", 32'(q4.size()), 32'h0);
    checkOutput("w16 scoreboard drained", 32'(q16.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
